// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle SLL/SRL/SRA shift unit that shifts STEP bit positions per clock.
// The handshake is start/busy/done, and the result is held in dout until the next completion.
// Optional feature macro: SEQ_SHIFTER_ROTATE_EN.
//   Defined:   op=11 rotates left.
//   Undefined: op=11 completes in one edge with dout=din, and no rotate logic is built.
module seq_shifter #(
   parameter int WIDTH   = 32,
   parameter int STEP    = 1,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   din,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   dout
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   // The step size needs one bit more than the shift amount, because STEP may equal WIDTH.
   localparam logic [SHAMT_W:0] STEP_K = (SHAMT_W+1)'(STEP);

`ifdef SEQ_SHIFTER_ROTATE_EN
   localparam logic ROL_BYPASS = 1'b0;
`else
   localparam logic ROL_BYPASS = 1'b1;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   work_q;
   logic [SHAMT_W-1:0] rem_q;
   logic [1:0]         opr_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   dout_q;

   logic [SHAMT_W:0]   k_d;
   logic [SHAMT_W-1:0] rem_d;
   logic [WIDTH-1:0]   shift_d;

   // Shift w by the constant amount amt.
   // SRA replicates the current MSB of w, so the original sign carries through every step.
   function automatic logic [WIDTH-1:0] shift_fn(input logic [WIDTH-1:0] w,
                                                  input logic [1:0]       o,
                                                  input int               amt);
      logic [WIDTH-1:0] r;
      case (o)
         OP_SLL:  r = w << amt;
         OP_SRL:  r = w >> amt;
         OP_SRA:  r = WIDTH'($signed(w) >>> amt);
`ifdef SEQ_SHIFTER_ROTATE_EN
         OP_ROL:  r = (w << amt) | (w >> (WIDTH - amt));
`endif
         default: r = w;
      endcase
      return r;
   endfunction

   // Per-step datapath.
   // k = min(STEP, rem). The shift result is a (STEP)-way select of constant shifts,
   // so no full barrel shifter is built.
   always_comb begin
      k_d     = ({1'b0, rem_q} < STEP_K) ? {1'b0, rem_q} : STEP_K;
      rem_d   = rem_q - k_d[SHAMT_W-1:0];
      shift_d = '0;
      for (int i = 1; i <= STEP; i++) begin
         shift_d = shift_d | ({WIDTH{k_d == (SHAMT_W+1)'(i)}} & shift_fn(work_q, opr_q, i));
      end
   end

   // Control FSM with the operand registers and the registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         rem_q   <= '0;
         opr_q   <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  work_q <= din;
                  rem_q  <= shamt;
                  opr_q  <= op;
                  busy_q <= 1'b1;
                  if ((shamt == '0) || (ROL_BYPASS && (op == OP_ROL))) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     dout_q  <= din;
                  end else begin
                     state_q <= S_SHIFT;
                     done_q  <= 1'b0;
                  end
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            S_SHIFT: begin
               work_q <= shift_d;
               rem_q  <= rem_d;
               if (rem_d == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  dout_q  <= shift_d;
               end else begin
                  state_q <= S_SHIFT;
                  done_q  <= 1'b0;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign dout = dout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter.
// Two instances (STEP=1 and STEP=4) share one stimulus stream.
// Each instance is checked every cycle against a latency/result model.
// Honours SEQ_SHIFTER_ROTATE_EN.
module tb_seq_shifter;

`ifdef SEQ_SHIFTER_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] din;
   logic [4:0]  shamt;

   logic [1:0]        busy_v;
   logic [1:0]        done_v;
   logic [1:0][31:0]  dout_v;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Full result in one go, computed from the operation definition.
   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] d, input int s);
      case (o)
         2'd0:    return d << s;
         2'd1:    return d >> s;
         2'd2:    return 32'($signed(d) >>> s);
         default: return ROT ? ((d << s) | (d >> (32 - s))) : d;
      endcase
   endfunction

   // Number of edges from the accept edge until done is visible.
   function automatic int ref_latency(input logic [1:0] o, input int s, input int step);
      if (s == 0 || (o == 2'd3 && !ROT)) return 1;
      return (s + step - 1) / step + 1;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int STEPG = (g == 0) ? 1 : 4;

      logic        m_busy;
      logic        m_done;
      logic [31:0] m_dout;
      logic [31:0] m_res;
      int          m_left;

      seq_shifter #(.WIDTH(32), .STEP(STEPG), .SHAMT_W(5)) u_dut (
         .clk   (clk),
         .rst   (rst),
         .start (start),
         .op    (op),
         .din   (din),
         .shamt (shamt),
         .busy  (busy_v[g]),
         .done  (done_v[g]),
         .dout  (dout_v[g])
      );

      // Reference model: countdown to completion, with the result precomputed at accept.
      always @(posedge clk) begin
         if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dout <= 32'd0;
            m_res  <= 32'd0;
            m_left <= 0;
         end else if (!m_busy) begin
            if (start) begin
               m_busy <= 1'b1;
               if (ref_latency(op, int'(shamt), STEPG) == 1) begin
                  m_done <= 1'b1;
                  m_dout <= ref_result(op, din, int'(shamt));
               end else begin
                  m_left <= ref_latency(op, int'(shamt), STEPG) - 1;
                  m_res  <= ref_result(op, din, int'(shamt));
               end
            end
         end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
         end else if (m_left == 1) begin
            m_done <= 1'b1;
            m_dout <= m_res;
            m_left <= 0;
         end else begin
            m_left <= m_left - 1;
         end
      end

      // Cycle-by-cycle compare of the DUT outputs against the model.
      always @(negedge clk) begin
         if (chk_en) begin
            chk($sformatf("step%0d_busy", STEPG), 32'(busy_v[g]), 32'(m_busy));
            chk($sformatf("step%0d_done", STEPG), 32'(done_v[g]), 32'(m_done));
            chk($sformatf("step%0d_dout", STEPG), dout_v[g], m_dout);
         end
      end
   end

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk);
         ok = (busy_v == 2'b00);
      end
      if (!ok) chk("wait_idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                         input bit lit, input logic [31:0] exp_dout,
                         input int lat1, input int lat4, input bit hammer);
      int lat [2];
      int bsy [2];
      bit fin = 1'b0;
      lat[0] = 0; lat[1] = 0; bsy[0] = 0; bsy[1] = 0;
      wait_idle();
      start = 1'b1; op = o; din = d; shamt = s;
      for (int c = 1; c <= 120 && !fin; c++) begin
         @(negedge clk);
         for (int j = 0; j < 2; j++) begin
            if (busy_v[j]) bsy[j]++;
            if (done_v[j] && lat[j] == 0) lat[j] = c;
         end
         start = (hammer && c <= 2) ? 1'b1 : 1'b0;
         op    = 2'($urandom_range(0, 3));
         din   = $urandom;
         shamt = 5'($urandom_range(0, 31));
         fin   = (busy_v == 2'b00) && (lat[0] != 0) && (lat[1] != 0);
      end
      start = 1'b0;
      if (!fin) chk("run_timeout", 32'd0, 32'd1);
      if (lit) begin
         chk("lit_dout_step1", dout_v[0], exp_dout);
         chk("lit_dout_step4", dout_v[1], exp_dout);
         chk("lit_lat_step1", 32'(lat[0]), 32'(lat1));
         chk("lit_lat_step4", 32'(lat[1]), 32'(lat4));
         chk("lit_busycyc_step1", 32'(bsy[0]), 32'(lat1));
         chk("lit_busycyc_step4", 32'(bsy[1]), 32'(lat4));
      end
   endtask

   initial begin
      int dn;
      rst = 1'b1; start = 1'b0; op = 2'd0; din = 32'd0; shamt = 5'd0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      rst = 1'b0;

      // Pin the model to hand-computed values.
      chk("pin_sll", ref_result(2'd0, 32'h0000_0001, 4), 32'h0000_0010);
      chk("pin_sra", ref_result(2'd2, 32'h8000_0000, 31), 32'hFFFF_FFFF);
      chk("pin_lat4", 32'(ref_latency(2'd1, 6, 4)), 32'd3);

      // Reset state.
      chk("reset_busy", 32'(busy_v), 32'd0);
      chk("reset_done", 32'(done_v), 32'd0);
      chk("reset_dout", dout_v[0] | dout_v[1], 32'd0);

      // Directed cases.
      run_op(2'd0, 32'h0000_0001, 5'd4,  1'b1, 32'h0000_0010, 5, 2, 1'b0);
      run_op(2'd2, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 32, 9, 1'b0);
      run_op(2'd1, 32'h8000_0000, 5'd31, 1'b1, 32'h0000_0001, 32, 9, 1'b0);
      run_op(2'd1, 32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, 1, 1, 1'b0);
      run_op(2'd1, 32'hF000_0000, 5'd6,  1'b1, 32'h03C0_0000, 7, 3, 1'b0);
      run_op(2'd0, 32'h0000_0001, 5'd8,  1'b1, 32'h0000_0100, 9, 3, 1'b1);
      run_op(2'd3, 32'h8000_0001, 5'd1,  1'b1,
             ROT ? 32'h0000_0003 : 32'h8000_0001, ROT ? 2 : 1, ROT ? 2 : 1, 1'b0);

      // Reset at the third edge of an operation: no done, and everything is cleared.
      wait_idle();
      start = 1'b1; op = 2'd0; din = 32'h0000_0001; shamt = 5'd8;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy_v), 32'd0);
      chk("abort_done", 32'(done_v), 32'd0);
      chk("abort_dout_step1", dout_v[0], 32'd0);
      chk("abort_dout_step4", dout_v[1], 32'd0);
      dn = 0;
      repeat (12) begin
         @(negedge clk);
         if (done_v != 2'b00) dn++;
      end
      chk("abort_no_done", 32'(dn), 32'd0);

      // Randomised operations.
      for (int n = 0; n < 150; n++) begin
         run_op(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)),
                1'b0, 32'd0, 0, 0, 1'($urandom_range(0, 1)));
      end

      wait_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
